// File: rtl/enc_param_reg.sv
// enc_param_reg: registered priority one-hot-to-binary encoder.
// A request vector is taken over a valid/ready handshake and converted into
// the index of its highest set bit, one cycle later, together with flags for
// all-zero and multi-hot words. A saturating counter tracks how many accepted
// words carried either flag. The output stage is a single skid-free register
// that can accept a new word in the same cycle it is drained.

module enc_param_reg #(
    parameter int out_width = 3,
    parameter int in_width  = 8,
    parameter int err_width = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [in_width-1:0]  a,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [out_width-1:0] y,
    output logic                 zero,
    output logic                 multi,
    input  logic                 clr_cnt,
    output logic [err_width-1:0] err_cnt
);

    // Every input bit position must map onto a representable index.
    if (in_width > (2 ** out_width)) begin : g_width_check
        $error("enc_param_reg: in_width exceeds 2**out_width");
    end

    localparam logic [err_width-1:0] ERR_MAX = '1;
    localparam logic [err_width-1:0] ERR_ONE = {{(err_width-1){1'b0}}, 1'b1};
    localparam logic [in_width-1:0]  IN_ONE  = {{(in_width-1){1'b0}}, 1'b1};

    // Index of the highest set bit; an all-zero word encodes to index zero.
    function automatic logic [out_width-1:0] enc_highest(input logic [in_width-1:0] v);
        logic [out_width-1:0] idx;
        idx = '0;
        for (int n = 0; n < in_width; n++) begin
            if (v[n]) begin
                idx = n[out_width-1:0];
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // True when the word has no bit set.
    function automatic logic is_zero(input logic [in_width-1:0] v);
        return (v == '0);
    endfunction

    // Clearing the lowest set bit leaves something only if two or more were set.
    function automatic logic is_multi(input logic [in_width-1:0] v);
        return ((v & (v - IN_ONE)) != '0);
    endfunction

    logic                 accept_s;
    logic                 drain_s;
    logic [out_width-1:0] enc_s;
    logic                 zero_s;
    logic                 multi_s;

    logic                 out_valid_d, out_valid_q;
    logic [out_width-1:0] y_d,         y_q;
    logic                 zero_d,      zero_q;
    logic                 multi_d,     multi_q;
    logic [err_width-1:0] err_cnt_d,   err_cnt_q;

    // Handshake qualification and combinational encoding of the incoming word.
    always_comb begin
        in_ready = en & (~out_valid_q | out_ready);
        accept_s = in_valid & in_ready;
        drain_s  = out_valid_q & out_ready;
        enc_s    = enc_highest(a);
        zero_s   = is_zero(a);
        multi_s  = is_multi(a);
    end

    // Next-state for the result register: load on accept, empty on drain-only.
    always_comb begin
        out_valid_d = out_valid_q;
        y_d         = y_q;
        zero_d      = zero_q;
        multi_d     = multi_q;
        if (accept_s) begin
            out_valid_d = 1'b1;
            y_d         = enc_s;
            zero_d      = zero_s;
            multi_d     = multi_s;
        end else if (drain_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Next-state for the error counter: clear wins, otherwise saturating count.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clr_cnt) begin
            err_cnt_d = '0;
        end else if (accept_s && (zero_s || multi_s) && (err_cnt_q != ERR_MAX)) begin
            err_cnt_d = err_cnt_q + ERR_ONE;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // State registers; reset discards any pending result and the error count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            y_q         <= '0;
            zero_q      <= 1'b0;
            multi_q     <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            zero_q      <= zero_d;
            multi_q     <= multi_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // Outputs come straight from flops.
    always_comb begin
        out_valid = out_valid_q;
        y         = y_q;
        zero      = zero_q;
        multi     = multi_q;
        err_cnt   = err_cnt_q;
    end

endmodule

// File: doc/enc_param_reg.md
Name: enc_param_reg

Overview:
Parameterized registered one-hot-to-binary encoder, the inverse of the team's parameterized binary-to-one-hot decoder. Accepts an in_width-bit request vector over a valid/ready handshake and returns a registered out_width-bit index. The highest set bit wins. Zero-hot and multi-hot inputs are flagged and counted. Used wherever a one-hot select or grant bus must be converted back to a binary code across a pipeline boundary.

Parameters:
out_width, 3, width of binary index output; in_width must be <= 2**out_width (compile-time constraint, elaboration error otherwise)
in_width, 8, width of one-hot input vector
err_width, 8, width of saturating error counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en  input  1  block enable; 0 blocks new input acceptance
in_valid  input  1  a is valid this cycle
in_ready  output  1  block can accept a this cycle
a  input  in_width  one-hot request vector
out_valid  output  1  y/zero/multi hold a valid result
out_ready  input  1  downstream accepts result this cycle
y  output  out_width  index of highest set bit of accepted a
zero  output  1  accepted a was all zeros
multi  output  1  accepted a had two or more bits set
clr_cnt  input  1  synchronous clear of err_cnt
err_cnt  output  err_width  count of accepted words with zero or multi set, saturating

Behaviour:
- Reset (rst_n low, async): out_valid=0, y=0, zero=0, multi=0, err_cnt=0. in_ready follows its combinational equation, so in_ready=en during reset.
- in_ready = en & (~out_valid | out_ready). Purely combinational, no dependence on in_valid.
- Accept = in_valid & in_ready. On accept, the next rising edge loads y, zero, multi and sets out_valid=1. Latency is exactly 1 cycle from accept to out_valid.
- Drain = out_valid & out_ready. Drain without accept clears out_valid at the next edge. y/zero/multi hold their last values and are don't-care while out_valid=0.
- Accept and drain in the same cycle: the new result loads and out_valid stays 1, giving one result per cycle with no bubble.
- While out_valid=1 and out_ready=0: y, zero and multi are stable; in_ready=0.
- en=0: no accept; a pending result remains valid and still drains normally. en does not affect err_cnt clearing.
- Encoding: y = largest n with a[n]=1.
  - a==0: y=0, zero=1, multi=0.
  - Exactly one bit set: zero=0, multi=0.
  - Two or more bits set: multi=1, and y is still the highest set index.
- err_cnt update:
  - Increments by 1 at the edge after an accept with zero|multi.
  - Saturates at 2**err_width-1 with no wrap.
  - clr_cnt=1 sets err_cnt to 0 at the next edge and takes priority over a simultaneous increment.
- Reset mid-operation: a pending result is discarded (out_valid=0) and the counter is cleared. No partial state survives.
- No X propagation: out-of-range conditions cannot occur because in_width <= 2**out_width. Unused codes are never produced.

Test Plan:
- Reset/idle: rst_n=0 with in_valid=1, a=8'h01 -> out_valid=0, err_cnt=0 throughout. After release with en=1, in_ready=1 and first accept produces out_valid=1 one cycle later.
- Exhaustive one-hot, out_ready=1 held: a=1<<n for n=0..7 back-to-back -> y=n each following cycle, zero=0, multi=0, out_valid continuously 1, err_cnt=0.
- Priority/multi: a=8'b1010_0100 -> y=7, multi=1. Then a=8'h00 -> y=0, zero=1. err_cnt=2.
- Backpressure: accept a=8'h10 with out_ready=0 for 3 cycles -> y=4 stable, in_ready=0, second in_valid word not taken. Raise out_ready -> drain and accept in the same cycle, no bubble.
- Saturation/clear (err_width=2): 5 accepted a=8'h00 -> err_cnt=3 (no wrap). clr_cnt=1 concurrent with another error accept -> err_cnt=0.
- Enable and reset mid-operation: en=0 with in_valid=1 -> in_ready=0, no new result. Pending result still drains. Assert rst_n low while out_valid=1 -> out_valid=0 immediately (async).
